axis_stall_block_detector: RTL and testbench

- Produces per-stream block flags for the deadlock monitors of an HLS-generated dataflow instance (e.g. an MVAU), i.e. the `axis_block_sigs` vector those monitors consume.
- Watches the AXI-Stream handshake (tvalid/tready) on each of the instance's stream ports.
- Flags a channel as blocked once it has stalled continuously for a programmable number of cycles.
- Also reports a summary flag and the index of the first channel that blocked.

---
 rtl/axis_stall_block_detector.sv | 117 +++++++++++
 tb/tb_axis_stall_block_detector.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_stall_block_detector.sv
// Per-channel AXI-Stream stall detector producing the block flags for dataflow deadlock monitors.
// Define AXIS_STALL_STICKY_EN to make the first-block record sticky until sticky_clr.
module axis_stall_block_detector #(
    parameter int unsigned       NUM_CH   = 3,
    parameter int unsigned       THRESH   = 16,
    parameter logic [NUM_CH-1:0] DIR_MASK = 3'b110,
    parameter int unsigned       CNT_W    = 5,
    parameter int unsigned       IDX_W    = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] axis_tvalid,
    input  logic [NUM_CH-1:0] axis_tready,
    input  logic              inst_active,
    input  logic              sticky_clr,
    output logic [NUM_CH-1:0] axis_block_sigs,
    output logic              block_any,
    output logic              first_block_vld,
    output logic [IDX_W-1:0]  first_block_idx
);

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
    // One bit wider so cnt + 1 cannot overflow in the flag compare.
    localparam logic [CNT_W:0]   THRESH_X = (CNT_W + 1)'(THRESH);

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] stall;
    logic [NUM_CH-1:0] flag_d, flag_q;
    logic              any_d, any_q;
    logic              vld_d, vld_q;
    logic              trigger;
    logic [IDX_W-1:0]  idx_d, idx_q, low_idx;

    always_comb begin
        stall = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (DIR_MASK[i]) begin
                stall[i] = inst_active & axis_tvalid[i] & ~axis_tready[i];
            end else begin
                stall[i] = inst_active & ~axis_tvalid[i] & axis_tready[i];
            end
        end
    end

    always_comb begin
        flag_d = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            cnt_d[i] = '0;
            if (stall[i]) begin
                cnt_d[i]  = (cnt_q[i] < THRESH_C) ? cnt_q[i] + 1'b1 : cnt_q[i];
                flag_d[i] = ({1'b0, cnt_q[i]} + 1'b1) >= THRESH_X;
            end
        end
        any_d = |flag_d;
    end

    // Descending scan so the lowest flagged index is the one left standing.
    always_comb begin
        low_idx = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (flag_d[i]) low_idx = IDX_W'(i);
        end
    end

`ifdef AXIS_STALL_STICKY_EN
    always_comb begin
        vld_d   = vld_q;
        idx_d   = idx_q;
        // A clear in the same cycle releases the record, letting a new onset capture.
        trigger = any_d & ~any_q & ~(vld_q & ~sticky_clr);
        if (trigger) begin
            vld_d = 1'b1;
            idx_d = low_idx;
        end else if (sticky_clr) begin
            vld_d = 1'b0;
        end
    end
`else
    logic unused_sticky_clr;
    assign unused_sticky_clr = sticky_clr;

    always_comb begin
        vld_d   = vld_q;
        idx_d   = idx_q;
        trigger = any_d & ~any_q;
        if (!any_d) begin
            vld_d = 1'b0;
        end else if (trigger) begin
            vld_d = 1'b1;
            idx_d = low_idx;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_CH); i++) cnt_q[i] <= '0;
            flag_q <= '0;
            any_q  <= 1'b0;
            vld_q  <= 1'b0;
            idx_q  <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) cnt_q[i] <= cnt_d[i];
            flag_q <= flag_d;
            any_q  <= any_d;
            vld_q  <= vld_d;
            idx_q  <= idx_d;
        end
    end

    assign axis_block_sigs = flag_q;
    assign block_any       = any_q;
    assign first_block_vld = vld_q;
    assign first_block_idx = idx_q;

endmodule

// File: tb/tb_axis_stall_block_detector.sv
// Directed self-checking bench for axis_stall_block_detector (THRESH=4, NUM_CH=3, DIR_MASK=3'b110).
module tb_axis_stall_block_detector;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] axis_tvalid;
    logic [2:0] axis_tready;
    logic       inst_active;
    logic       sticky_clr;
    logic [2:0] axis_block_sigs;
    logic       block_any;
    logic       first_block_vld;
    logic [1:0] first_block_idx;

    int checks = 0;
    int errors = 0;

`ifdef AXIS_STALL_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    axis_stall_block_detector #(
        .NUM_CH  (3),
        .THRESH  (4),
        .DIR_MASK(3'b110),
        .CNT_W   (3),
        .IDX_W   (2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .axis_tvalid    (axis_tvalid),
        .axis_tready    (axis_tready),
        .inst_active    (inst_active),
        .sticky_clr     (sticky_clr),
        .axis_block_sigs(axis_block_sigs),
        .block_any      (block_any),
        .first_block_vld(first_block_vld),
        .first_block_idx(first_block_idx)
    );

    always #5 clock = ~clock;

    // Advance n rising edges; outputs are sampled 1 time unit after the last edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive(input logic act, input logic [2:0] v, input logic [2:0] r);
        inst_active = act;
        axis_tvalid = v;
        axis_tready = r;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sticky_clr = 1'b0;
        drive(1'($urandom), 3'($urandom), 3'($urandom));
        step(1);
        drive(1'b1, 3'b010, 3'b000);
        step(1);
        checks++;
        if ({axis_block_sigs, block_any, first_block_vld, first_block_idx} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got sigs=%b any=%b vld=%b idx=%0d, expected all 0",
                     axis_block_sigs, block_any, first_block_vld, first_block_idx);
        end
        drive(1'b1, 3'b000, 3'b000);
        reset = 1'b0;
        step(1);
        checks++;
        if (axis_block_sigs !== 3'b000) begin
            errors++;
            $display("FAIL reset_no_flag: got %b expected 000", axis_block_sigs);
        end
    endtask

    task automatic test_threshold();
        drive(1'b1, 3'b010, 3'b000);
        step(3);
        checks++;
        if (axis_block_sigs !== 3'b000 || block_any !== 1'b0) begin
            errors++;
            $display("FAIL thresh_edge3: got sigs=%b any=%b expected 000/0",
                     axis_block_sigs, block_any);
        end
        step(1);
        checks++;
        if (axis_block_sigs !== 3'b010 || block_any !== 1'b1) begin
            errors++;
            $display("FAIL thresh_edge4: got sigs=%b any=%b expected 010/1",
                     axis_block_sigs, block_any);
        end
        checks++;
        if (first_block_vld !== 1'b1 || first_block_idx !== 2'd1) begin
            errors++;
            $display("FAIL thresh_first: got vld=%b idx=%0d expected 1/1",
                     first_block_vld, first_block_idx);
        end
    endtask

    task automatic test_release();
        drive(1'b1, 3'b010, 3'b010);
        step(1);
        checks++;
        if (axis_block_sigs !== 3'b000 || block_any !== 1'b0) begin
            errors++;
            $display("FAIL release_drop: got sigs=%b any=%b expected 000/0",
                     axis_block_sigs, block_any);
        end
        checks++;
        if (first_block_vld !== STICKY || first_block_idx !== 2'd1) begin
            errors++;
            $display("FAIL release_vld: got vld=%b idx=%0d expected %b/1",
                     first_block_vld, first_block_idx, STICKY);
        end
        drive(1'b1, 3'b010, 3'b000);
        step(3);
        checks++;
        if (axis_block_sigs !== 3'b000) begin
            errors++;
            $display("FAIL restart_edge3: got %b expected 000", axis_block_sigs);
        end
        step(1);
        checks++;
        if (axis_block_sigs !== 3'b010) begin
            errors++;
            $display("FAIL restart_edge4: got %b expected 010", axis_block_sigs);
        end
        drive(1'b1, 3'b000, 3'b000);
        step(1);
    endtask

    task automatic test_direction_idle();
        drive(1'b1, 3'b000, 3'b001);
        step(3);
        checks++;
        if (axis_block_sigs !== 3'b000) begin
            errors++;
            $display("FAIL starve_edge3: got %b expected 000", axis_block_sigs);
        end
        step(1);
        checks++;
        if (axis_block_sigs !== 3'b001 || block_any !== 1'b1) begin
            errors++;
            $display("FAIL starve_edge4: got sigs=%b any=%b expected 001/1",
                     axis_block_sigs, block_any);
        end
        drive(1'b1, 3'b000, 3'b000);
        step(6);
        checks++;
        if (axis_block_sigs !== 3'b000 || block_any !== 1'b0) begin
            errors++;
            $display("FAIL idle_link: got sigs=%b any=%b expected 000/0",
                     axis_block_sigs, block_any);
        end
        drive(1'b0, 3'b010, 3'b001);
        step(6);
        checks++;
        if (axis_block_sigs !== 3'b000 || block_any !== 1'b0) begin
            errors++;
            $display("FAIL inactive: got sigs=%b any=%b expected 000/0",
                     axis_block_sigs, block_any);
        end
        drive(1'b1, 3'b000, 3'b000);
        step(1);
    endtask

    task automatic test_simultaneous_saturation();
        int bad;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        drive(1'b1, 3'b100, 3'b001);
        step(4);
        checks++;
        if (axis_block_sigs !== 3'b101 || first_block_vld !== 1'b1 || first_block_idx !== 2'd0) begin
            errors++;
            $display("FAIL simul_onset: got sigs=%b vld=%b idx=%0d expected 101/1/0",
                     axis_block_sigs, first_block_vld, first_block_idx);
        end
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            step(1);
            if (axis_block_sigs !== 3'b101 || block_any !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL saturate_hold: got %0d bad cycles expected 0 (last sigs=%b)",
                     bad, axis_block_sigs);
        end
        reset = 1'b1;
        step(1);
        checks++;
        if ({axis_block_sigs, block_any, first_block_vld, first_block_idx} !== 7'b0) begin
            errors++;
            $display("FAIL midop_reset: got sigs=%b any=%b vld=%b idx=%0d expected all 0",
                     axis_block_sigs, block_any, first_block_vld, first_block_idx);
        end
        reset = 1'b0;
        step(3);
        checks++;
        if (axis_block_sigs !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_count: got %b expected 000", axis_block_sigs);
        end
        step(1);
        checks++;
        if (axis_block_sigs !== 3'b101) begin
            errors++;
            $display("FAIL post_reset_edge4: got %b expected 101", axis_block_sigs);
        end
        drive(1'b1, 3'b000, 3'b000);
        step(1);
    endtask

    task automatic test_sticky();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        drive(1'b1, 3'b100, 3'b000);
        step(4);
        checks++;
        if (first_block_vld !== 1'b1 || first_block_idx !== 2'd2) begin
            errors++;
            $display("FAIL sticky_cap: got vld=%b idx=%0d expected 1/2",
                     first_block_vld, first_block_idx);
        end
        drive(1'b1, 3'b100, 3'b100);
        step(1);
        checks++;
        if (first_block_vld !== STICKY || first_block_idx !== 2'd2 || block_any !== 1'b0) begin
            errors++;
            $display("FAIL sticky_release: got vld=%b idx=%0d any=%b expected %b/2/0",
                     first_block_vld, first_block_idx, block_any, STICKY);
        end
        drive(1'b1, 3'b000, 3'b001);
        step(4);
        checks++;
        if (first_block_vld !== 1'b1 || first_block_idx !== (STICKY ? 2'd2 : 2'd0)) begin
            errors++;
            $display("FAIL sticky_later: got vld=%b idx=%0d expected 1/%0d",
                     first_block_vld, first_block_idx, STICKY ? 2 : 0);
        end
        drive(1'b1, 3'b000, 3'b000);
        sticky_clr = 1'b1;
        step(1);
        sticky_clr = 1'b0;
        checks++;
        if (first_block_vld !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clr: got vld=%b expected 0", first_block_vld);
        end
        drive(1'b1, 3'b010, 3'b000);
        step(4);
        drive(1'b1, 3'b000, 3'b000);
        step(1);
        checks++;
        if (first_block_vld !== STICKY || first_block_idx !== 2'd1) begin
            errors++;
            $display("FAIL sticky_rec1: got vld=%b idx=%0d expected %b/1",
                     first_block_vld, first_block_idx, STICKY);
        end
        drive(1'b1, 3'b000, 3'b001);
        step(3);
        sticky_clr = 1'b1;
        step(1);
        sticky_clr = 1'b0;
        checks++;
        if (first_block_vld !== 1'b1 || first_block_idx !== 2'd0) begin
            errors++;
            $display("FAIL clr_vs_capture: got vld=%b idx=%0d expected 1/0",
                     first_block_vld, first_block_idx);
        end
    endtask

    initial begin
        reset = 1'b1;
        sticky_clr = 1'b0;
        drive(1'b0, 3'b000, 3'b000);
        test_reset();
        test_threshold();
        test_release();
        test_direction_idle();
        test_simultaneous_saturation();
        test_sticky();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
